// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse digit decoder:
//   - FSM state encoding (IDLE, PRESS, GAP, EMIT)
//   - symbol encoding (DOT = 0, DASH = 1)
//   - the ten 5-symbol digit patterns; the first symbol keyed is the MSB
//   - decode_code(): pattern lookup returning {valid, digit}
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_EMIT  = 2'd3
    } morse_state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int CODE_LEN = 5;

    // Index = digit value. Bit 4 is the first symbol of the code.
    localparam logic [CODE_LEN-1:0] DIGIT_PAT [10] = '{
        5'b11111,  // 0 -----
        5'b01111,  // 1 .----
        5'b00111,  // 2 ..---
        5'b00011,  // 3 ...--
        5'b00001,  // 4 ....-
        5'b00000,  // 5 .....
        5'b10000,  // 6 -....
        5'b11000,  // 7 --...
        5'b11100,  // 8 ---..
        5'b11110   // 9 ----.
    };

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } decode_t;

    function automatic decode_t decode_code(input logic [CODE_LEN-1:0] code);
        decode_t r;
        r.valid = 1'b0;
        r.digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code == DIGIT_PAT[i]) begin
                r.valid = 1'b1;
                r.digit = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_digit_decoder_key_sync.sv
// key_sync
// Two-flop synchronizer for the asynchronous Morse key plus edge detection
// on the synchronized level.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (clears all flops)
//   key   in   raw debounced key, asynchronous to clk
//   key_s out  synchronized key level
//   rise  out  high for one cycle on the first cycle key_s is high
//   fall  out  high for one cycle on the first cycle key_s is low
module key_sync (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_s,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic key_d;  // key_s delayed by one cycle, for edge detection

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            key_d  <= 1'b0;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
            key_d  <= sync_2;
        end
    end

    assign key_s = sync_2;
    assign rise  = sync_2 & ~key_d;
    assign fall  = ~sync_2 & key_d;

endmodule

// File: rtl/morse_digit_decoder.sv
// morse_digit_decoder
// Decodes 5-symbol Morse digits from a single key. Press length picks dot or
// dash; a long enough low gap (or the 5th symbol) closes the code.
// Optional feature macro: MORSE_ERR_OUT_EN -- when defined, err pulses for
// invalid or incomplete codes; when undefined, err is tied low and such codes
// are dropped silently.
// Parameters:
//   DASH_MIN   key-high cycles at or above which a press is a dash
//   GAP_MAX    key-low cycles that close a partial code
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enable     in   decoder active; low aborts the code and holds IDLE
//   key        in   debounced key, asynchronous to clk
//   user_input out  last decoded digit, valid together with load
//   load       out  one-cycle strobe: new digit on user_input
//   err        out  one-cycle strobe: invalid/incomplete code
//   sym_count  out  symbols captured in the current code (0-5)
module morse_digit_decoder
    import morse_pkg::*;
#(
    parameter int DASH_MIN = 12500000,
    parameter int GAP_MAX  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key,
    output logic [3:0] user_input,
    output logic       load,
    output logic       err,
    output logic [2:0] sym_count
);

    localparam int PW = $clog2(DASH_MIN + 1);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic [PW-1:0] PRESS_SAT = PW'(DASH_MIN);
    localparam logic [GW-1:0] GAP_LIM   = GW'(GAP_MAX);

    logic key_s;
    logic rise;
    logic fall;

    key_sync u_key_sync (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .key_s (key_s),
        .rise  (rise),
        .fall  (fall)
    );

    morse_state_e        state, state_n;
    logic [PW-1:0]       press_cnt, press_n, press_inc;
    logic [GW-1:0]       gap_cnt, gap_n, gap_inc;
    logic [CODE_LEN-1:0] shreg, shreg_n;
    logic [2:0]          sym_q, sym_n;
    logic [3:0]          user_q, user_n;
    decode_t             dec;
    logic                emit_live;
    logic                emit_ok;
    logic                sym_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            press_cnt <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            sym_q     <= '0;
            user_q    <= '0;
        end else begin
            state     <= state_n;
            press_cnt <= press_n;
            gap_cnt   <= gap_n;
            shreg     <= shreg_n;
            sym_q     <= sym_n;
            user_q    <= user_n;
        end
    end

    always_comb begin
        state_n = state;
        press_n = press_cnt;
        gap_n   = gap_cnt;
        shreg_n = shreg;
        sym_n   = sym_q;
        user_n  = user_q;

        // The press cycle that sees the fall is counted too, so a press of
        // exactly DASH_MIN key_s-high cycles reaches the threshold.
        press_inc = (press_cnt == PRESS_SAT) ? press_cnt : press_cnt + PW'(1);
        gap_inc   = gap_cnt + GW'(1);
        sym_bit   = (press_inc == PRESS_SAT) ? SYM_DASH : SYM_DOT;

        dec       = decode_code(shreg);
        // Strobes are gated by rst/enable so the abort/reset cycle is silent.
        emit_live = (state == ST_EMIT) && enable && !rst;
        emit_ok   = emit_live && (sym_q == 3'd5) && dec.valid;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_PRESS;
                    press_n = '0;
                end
            end
            ST_PRESS: begin
                press_n = press_inc;
                if (fall) begin
                    shreg_n = {shreg[CODE_LEN-2:0], sym_bit};
                    sym_n   = sym_q + 3'd1;
                    if (sym_q == 3'd4) begin
                        state_n = ST_EMIT;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = '0;
                    end
                end
            end
            ST_GAP: begin
                gap_n = gap_inc;
                // A rise in the expiry cycle still continues the code.
                if (rise) begin
                    state_n = ST_PRESS;
                    press_n = '0;
                end else if (gap_inc == GAP_LIM) begin
                    state_n = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_n = ST_IDLE;
                shreg_n = '0;
                sym_n   = '0;
                if (emit_ok) begin
                    user_n = dec.digit;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_n = ST_IDLE;
            shreg_n = '0;
            sym_n   = '0;
        end
    end

    // Bypass so the new digit is already visible in the load cycle.
    assign user_input = emit_ok ? dec.digit : user_q;
    assign load       = emit_ok;
    assign sym_count  = sym_q;

`ifdef MORSE_ERR_OUT_EN
    assign err = emit_live && !emit_ok;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_morse_digit_decoder.sv
// tb_morse_digit_decoder
// Self-checking bench for morse_digit_decoder with DASH_MIN = 4, GAP_MAX = 10.
// The reference model works on Morse strings ("." / "-") built from the
// digit rules; load pulses are checked against an expected-digit queue.
module tb_morse_digit_decoder;

    localparam int DASH_MIN_TB = 4;
    localparam int GAP_MAX_TB  = 10;
    localparam int SETTLE      = GAP_MAX_TB + 8;

`ifdef MORSE_ERR_OUT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       enable;
    logic       key;
    logic [3:0] user_input;
    logic       load;
    logic       err;
    logic [2:0] sym_count;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int err_cnt  = 0;
    int last_digit = 0;

    logic [3:0] exp_q[$];
    logic [2:0] sc_hist[$];
    logic [2:0] sc_last = 3'd0;
    logic       load_d  = 1'b0;
    logic       err_d   = 1'b0;

    morse_digit_decoder #(
        .DASH_MIN (DASH_MIN_TB),
        .GAP_MAX  (GAP_MAX_TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .key        (key),
        .user_input (user_input),
        .load       (load),
        .err        (err),
        .sym_count  (sym_count)
    );

    // ---------------- clock / timeout ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (load || err) begin
            n_checks++;
            if (load && err) begin
                n_fail++;
                $display("FAIL strobe_exclusive: load=%0b err=%0b, required not both", load, err);
            end
            n_checks++;
            if (load_d || err_d) begin
                n_fail++;
                $display("FAIL strobe_width: strobe high two cycles running, required single cycle");
            end
        end
        if (load) begin
            load_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected: user_input=%0d, required no load", user_input);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (user_input !== e) begin
                    n_fail++;
                    $display("FAIL load_digit: got %0d, expected %0d", user_input, e);
                end
            end
        end
        if (err) err_cnt++;
        if (sym_count !== sc_last) begin
            sc_hist.push_back(sym_count);
            sc_last = sym_count;
        end
        load_d = load;
        err_d  = err;
    end

    // ---------------- reference model ----------------
    function automatic string morse_of(input int d);
        string m;
        bit    dash;
        m = "";
        for (int k = 0; k < 5; k++) begin
            if (d == 0)      dash = 1'b1;
            else if (d <= 5) dash = (k >= d);
            else             dash = (k < d - 5);
            if (dash) m = {m, "-"};
            else      m = {m, "."};
        end
        return m;
    endfunction

    function automatic int model_decode(input int n, input int durs[5]);
        string code;
        code = "";
        for (int i = 0; i < n; i++) begin
            if (durs[i] >= DASH_MIN_TB) code = {code, "-"};
            else                        code = {code, "."};
        end
        for (int d = 0; d < 10; d++) begin
            if (code == morse_of(d)) return d;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_symbols(input int n, input int durs[5], input int gap);
        for (int i = 0; i < n; i++) begin
            key = 1'b1;
            tick(durs[i]);
            key = 1'b0;
            tick(gap);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; key = 1'b0;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (user_input !== 4'd0) begin n_fail++; $display("FAIL reset_user_input: got %0d, expected 0", user_input); end
        n_checks++;
        if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %0b, expected 0", load); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, expected 0", err); end
        n_checks++;
        if (sym_count !== 3'd0) begin n_fail++; $display("FAIL reset_sym_count: got %0d, expected 0", sym_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_digit_one();
        int l0, e0;
        bit ok;
        logic [2:0] exp_sc[6];
        exp_sc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        l0 = load_cnt; e0 = err_cnt;
        sc_hist.delete();
        exp_q.push_back(4'd1);
        send_symbols(5, '{2, 6, 6, 6, 6}, 3);
        tick(SETTLE);
        last_digit = 1;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL one_load_count: got %0d, expected 1", load_cnt - l0); end
        n_checks++;
        if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL one_err_count: got %0d, expected 0", err_cnt - e0); end
        n_checks++;
        if (user_input !== 4'd1) begin n_fail++; $display("FAIL one_user_input: got %0d, expected 1", user_input); end
        ok = (sc_hist.size() == 6);
        if (ok) for (int i = 0; i < 6; i++) if (sc_hist[i] !== exp_sc[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL one_sym_count_steps: got %0d changes, expected 1,2,3,4,5,0", sc_hist.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_all_dash();
        int l0;
        l0 = load_cnt;
        exp_q.push_back(4'd0);
        send_symbols(5, '{5, 5, 5, 5, 5}, 3);
        tick(SETTLE);
        last_digit = 0;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL zero_load_count: got %0d, expected 1", load_cnt - l0); end
        n_checks++;
        if (user_input !== 4'd0) begin n_fail++; $display("FAIL zero_user_input: got %0d, expected 0", user_input); end
        @(posedge clk); #1;
    endtask

    task automatic test_boundary();
        int l0;
        l0 = load_cnt;
        exp_q.push_back(4'd2);
        send_symbols(5, '{3, 3, 4, 4, 4}, 3);
        tick(SETTLE);
        last_digit = 2;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL boundary_load_count: got %0d, expected 1", load_cnt - l0); end
        n_checks++;
        if (user_input !== 4'd2) begin n_fail++; $display("FAIL boundary_user_input: got %0d, expected 2", user_input); end
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        int l0, e0;
        l0 = load_cnt; e0 = err_cnt;
        send_symbols(3, '{2, 2, 2, 0, 0}, 3);
        tick(SETTLE);
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 0) begin n_fail++; $display("FAIL partial_load_count: got %0d, expected 0", load_cnt - l0); end
        n_checks++;
        if (err_cnt - e0 != (ERR_EN ? 1 : 0)) begin n_fail++; $display("FAIL partial_err_count: got %0d, expected %0d", err_cnt - e0, ERR_EN ? 1 : 0); end
        n_checks++;
        if (user_input !== 4'(last_digit)) begin n_fail++; $display("FAIL partial_user_hold: got %0d, expected %0d", user_input, last_digit); end
        n_checks++;
        if (sym_count !== 3'd0) begin n_fail++; $display("FAIL partial_sym_clear: got %0d, expected 0", sym_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int l0;
        l0 = load_cnt;
        exp_q.push_back(4'd5);
        send_symbols(4, '{2, 2, 2, 2, 0}, 3);
        key = 1'b1;
        tick(2);
        key = 1'b0;              // final release, just after edge P0
        @(posedge clk);          // P1
        @(posedge clk);          // P2
        @(negedge clk);
        n_checks++;
        if (load !== 1'b0) begin n_fail++; $display("FAIL latency_early: load=%0b after 2 edges, expected 0", load); end
        @(posedge clk);          // P3
        @(negedge clk);
        n_checks++;
        if (load !== 1'b1) begin n_fail++; $display("FAIL latency_on_time: load=%0b after 3 edges, expected 1", load); end
        n_checks++;
        if (user_input !== 4'd5) begin n_fail++; $display("FAIL latency_digit: got %0d, expected 5", user_input); end
        @(posedge clk); #1;
        tick(SETTLE);
        last_digit = 5;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL latency_load_count: got %0d, expected 1", load_cnt - l0); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int l0, e0;
        l0 = load_cnt; e0 = err_cnt;
        send_symbols(3, '{6, 6, 2, 0, 0}, 3);
        enable = 1'b0;
        tick(SETTLE);
        @(negedge clk);
        n_checks++;
        if ((load_cnt - l0) + (err_cnt - e0) != 0) begin n_fail++; $display("FAIL abort_silent: got %0d strobes, expected 0", (load_cnt - l0) + (err_cnt - e0)); end
        n_checks++;
        if (sym_count !== 3'd0) begin n_fail++; $display("FAIL abort_sym_clear: got %0d, expected 0", sym_count); end
        @(posedge clk); #1;
        enable = 1'b1;
        tick(2);
        exp_q.push_back(4'd7);
        send_symbols(5, '{6, 6, 2, 2, 2}, 3);
        tick(SETTLE);
        last_digit = 7;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL abort_then_load: got %0d, expected 1", load_cnt - l0); end
        n_checks++;
        if (user_input !== 4'd7) begin n_fail++; $display("FAIL abort_then_digit: got %0d, expected 7", user_input); end
        @(posedge clk); #1;
    endtask

    task automatic test_enable_key_high();
        int l0, e0;
        l0 = load_cnt; e0 = err_cnt;
        enable = 1'b0;
        key = 1'b1;
        tick(5);
        enable = 1'b1;
        tick(8);
        @(negedge clk);
        n_checks++;
        if (sym_count !== 3'd0) begin n_fail++; $display("FAIL enable_keyhigh_sym: got %0d, expected 0", sym_count); end
        @(posedge clk); #1;
        key = 1'b0;
        tick(SETTLE);
        @(negedge clk);
        n_checks++;
        if ((load_cnt - l0) + (err_cnt - e0) != 0) begin n_fail++; $display("FAIL enable_keyhigh_strobe: got %0d strobes, expected 0", (load_cnt - l0) + (err_cnt - e0)); end
        n_checks++;
        if (user_input !== 4'(last_digit)) begin n_fail++; $display("FAIL enable_keyhigh_hold: got %0d, expected %0d", user_input, last_digit); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_press();
        int l0;
        send_symbols(3, '{6, 6, 6, 0, 0}, 3);
        key = 1'b1;
        tick(2);                 // mid-press of the 4th symbol
        rst = 1'b1;
        key = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (user_input !== 4'd0) begin n_fail++; $display("FAIL midrst_user_input: got %0d, expected 0", user_input); end
        n_checks++;
        if (sym_count !== 3'd0) begin n_fail++; $display("FAIL midrst_sym_count: got %0d, expected 0", sym_count); end
        n_checks++;
        if (load !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: load=%0b err=%0b, expected 0 0", load, err); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_digit = 0;
        tick(3);
        l0 = load_cnt;
        exp_q.push_back(4'd8);
        send_symbols(5, '{6, 6, 6, 2, 2}, 3);
        tick(SETTLE);
        last_digit = 8;
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL midrst_recover_load: got %0d, expected 1", load_cnt - l0); end
        n_checks++;
        if (user_input !== 4'd8) begin n_fail++; $display("FAIL midrst_recover_digit: got %0d, expected 8", user_input); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int l0, e0, exp_load, exp_err;
        int durs[5];
        int n, mode, d, gap;
        string m;
        l0 = load_cnt; e0 = err_cnt;
        exp_load = 0; exp_err = 0;
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            n = 5;
            for (int k = 0; k < 5; k++) durs[k] = $urandom_range(1, 9);
            if (mode == 0) begin
                d = $urandom_range(0, 9);
                m = morse_of(d);
                for (int k = 0; k < 5; k++)
                    durs[k] = (m.getc(k) == 8'h2d) ? $urandom_range(4, 9) : $urandom_range(1, 3);
            end else if (mode == 2) begin
                n = $urandom_range(1, 4);
            end
            d = model_decode(n, durs);
            if (d >= 0) begin
                exp_q.push_back(4'(d));
                exp_load++;
                last_digit = d;
            end else begin
                exp_err++;
            end
            gap = $urandom_range(1, 8);
            send_symbols(n, durs, gap);
            tick(SETTLE);
        end
        @(negedge clk);
        n_checks++;
        if (load_cnt - l0 != exp_load) begin n_fail++; $display("FAIL random_load_count: got %0d, expected %0d", load_cnt - l0, exp_load); end
        n_checks++;
        if (err_cnt - e0 != (ERR_EN ? exp_err : 0)) begin n_fail++; $display("FAIL random_err_count: got %0d, expected %0d", err_cnt - e0, ERR_EN ? exp_err : 0); end
        n_checks++;
        if (user_input !== 4'(last_digit)) begin n_fail++; $display("FAIL random_last_digit: got %0d, expected %0d", user_input, last_digit); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_pending: %0d digits never loaded, expected 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1; enable = 1'b1; key = 1'b0;
        test_reset();
        test_digit_one();
        test_all_dash();
        test_boundary();
        test_partial();
        test_latency();
        test_abort();
        test_enable_key_high();
        test_reset_mid_press();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
